// File: rtl/pb_err_responder.sv
// AXI4 subordinate for unpopulated mesh positions: every write and read is
// answered with a fixed error response, and saturating counters tally them.
module pb_err_responder #(
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned DataWidth = 64,
   parameter logic [1:0]  RespCode  = 2'b11,
   parameter logic [63:0] ReadData  = 64'hCA11_AB1E_BADC_AB1E,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [1:0]           b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [7:0]           ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [1:0]           r_resp_o,
   output logic                 r_last_o,
   output logic [CntWidth-1:0]  wr_cnt_o,
   output logic [CntWidth-1:0]  rd_cnt_o
);

   localparam logic [DataWidth-1:0] RdPattern = DataWidth'(ReadData);

   typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wr_state_e;
   typedef enum logic       {RIDLE, RDATA}        rd_state_e;

   wr_state_e           wr_state, wr_next;
   rd_state_e           rd_state, rd_next;
   logic [IdWidth-1:0]  wr_id, rd_id;
   logic [7:0]          rd_len, rd_beat;
   logic [CntWidth-1:0] wr_cnt, rd_cnt;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (&v) ? v : v + CntWidth'(1);
   endfunction

   // Write path: all outputs decode from state only, so no input reaches an output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wr_state <= WIDLE;
      else         wr_state <= wr_next;
   end

   always_comb begin
      wr_next    = wr_state;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      case (wr_state)
         WIDLE: begin
            aw_ready_o = 1'b1;
            if (aw_valid_i) wr_next = WDATA;
         end
         WDATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i && w_last_i) wr_next = WRESP;
         end
         WRESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) wr_next = WIDLE;
         end
         default: wr_next = WIDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_id  <= '0;
         wr_cnt <= '0;
      end else begin
         if (aw_valid_i && aw_ready_o) wr_id  <= aw_id_i;
         if (b_valid_o && b_ready_i)   wr_cnt <= sat_inc(wr_cnt);
      end
   end

   // Read path
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_state <= RIDLE;
      else         rd_state <= rd_next;
   end

   always_comb begin
      rd_next    = rd_state;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      r_last_o   = 1'b0;
      case (rd_state)
         RIDLE: begin
            ar_ready_o = 1'b1;
            if (ar_valid_i) rd_next = RDATA;
         end
         RDATA: begin
            r_valid_o = 1'b1;
            r_last_o  = (rd_beat == rd_len);
            if (r_ready_i && r_last_o) rd_next = RIDLE;
         end
         default: rd_next = RIDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_id   <= '0;
         rd_len  <= '0;
         rd_beat <= '0;
         rd_cnt  <= '0;
      end else begin
         if (ar_valid_i && ar_ready_o) begin
            rd_id   <= ar_id_i;
            rd_len  <= ar_len_i;
            rd_beat <= '0;
         end else if (r_valid_o && r_ready_i) begin
            if (r_last_o) rd_cnt  <= sat_inc(rd_cnt);
            else          rd_beat <= rd_beat + 8'd1;
         end
      end
   end

   assign b_id_o   = wr_id;
   assign b_resp_o = RespCode;
   assign r_id_o   = rd_id;
   assign r_data_o = RdPattern;
   assign r_resp_o = RespCode;
   assign wr_cnt_o = wr_cnt;
   assign rd_cnt_o = rd_cnt;

endmodule

// File: tb/tb_pb_err_responder.sv
// Bench for pb_err_responder: directed scenarios plus randomized traffic scored
// against a transaction-level model of the error responder.
module tb_pb_err_responder;

   localparam int          IW  = 4;
   localparam int          DW  = 64;
   localparam int          CW  = 2;
   localparam logic [63:0] RD  = 64'hCA11_AB1E_BADC_AB1E;
   localparam logic [1:0]  ERR = 2'b11;

   logic          clk, rst_n;
   logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic [IW-1:0] aw_id, b_id, ar_id, r_id;
   logic [1:0]    b_resp, r_resp;
   logic          ar_valid, ar_ready, r_valid, r_ready, r_last;
   logic [7:0]    ar_len;
   logic [DW-1:0] r_data;
   logic [CW-1:0] wr_cnt, rd_cnt;

   int vec, errs;
   int exp_wr, exp_rd;

   pb_err_responder #(.IdWidth(IW), .DataWidth(DW), .RespCode(ERR), .ReadData(RD), .CntWidth(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_len_i(ar_len),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
      .r_resp_o(r_resp), .r_last_o(r_last),
      .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter value a saturating CW-bit counter shows after n completions.
   function automatic logic [CW-1:0] sat(input int n);
      return (n >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      aw_valid = 0; aw_id = 0; w_valid = 0; w_last = 0; b_ready = 0;
      ar_valid = 0; ar_id = 0; ar_len = 0; r_ready = 0;
      repeat (3) @(negedge clk);
      vec++;
      if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last} !== 6'b110000) begin
         errs++; $display("FAIL reset_ctrl got %b want 110000", {aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last});
      end
      vec++;
      if ({b_id, r_id, wr_cnt, rd_cnt} !== '0) begin
         errs++; $display("FAIL reset_data b_id=%0d r_id=%0d wr=%0d rd=%0d want all 0", b_id, r_id, wr_cnt, rd_cnt);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vec++;
      if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000) begin
         errs++; $display("FAIL post_reset_idle got %b want 11000", {aw_ready, ar_ready, w_ready, b_valid, r_valid});
      end
      exp_wr = 0; exp_rd = 0;
   endtask

   task automatic test_single_write();
      aw_valid = 1; aw_id = 4'd5;
      @(negedge clk);
      aw_valid = 0;
      vec++;
      if ({w_ready, aw_ready} !== 2'b10) begin
         errs++; $display("FAIL sw_wready got w_ready=%b aw_ready=%b want 1/0", w_ready, aw_ready);
      end
      w_valid = 1; w_last = 1; b_ready = 1;
      @(negedge clk);
      w_valid = 0; w_last = 0;
      vec++;
      if ({b_valid, b_id, b_resp, w_ready} !== {1'b1, 4'd5, ERR, 1'b0}) begin
         errs++; $display("FAIL sw_bresp got valid=%b id=%0d resp=%b w_ready=%b want 1/5/11/0", b_valid, b_id, b_resp, w_ready);
      end
      @(negedge clk);
      b_ready = 0;
      exp_wr++;
      vec++;
      if ({b_valid, aw_ready, wr_cnt} !== {1'b0, 1'b1, sat(exp_wr)}) begin
         errs++; $display("FAIL sw_done got b_valid=%b aw_ready=%b wr_cnt=%0d want 0/1/%0d", b_valid, aw_ready, wr_cnt, sat(exp_wr));
      end
   endtask

   task automatic test_read_burst();
      ar_valid = 1; ar_id = 4'd3; ar_len = 8'd3; r_ready = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ar_valid = 0;
         vec++;
         if ({r_valid, r_id, r_data, r_resp, r_last, ar_ready} !== {1'b1, 4'd3, RD, ERR, (k == 3), 1'b0}) begin
            errs++; $display("FAIL rb_beat%0d got v=%b id=%0d data=%h resp=%b last=%b ar_ready=%b", k, r_valid, r_id, r_data, r_resp, r_last, ar_ready);
         end
      end
      @(negedge clk);
      r_ready = 0;
      exp_rd++;
      vec++;
      if ({r_valid, ar_ready, rd_cnt} !== {1'b0, 1'b1, sat(exp_rd)}) begin
         errs++; $display("FAIL rb_done got r_valid=%b ar_ready=%b rd_cnt=%0d want 0/1/%0d", r_valid, ar_ready, rd_cnt, sat(exp_rd));
      end
   endtask

   task automatic test_backpressure();
      int            beats, cyc;
      logic          rr, prev_stall;
      logic [IW+DW:0] prev;
      ar_valid = 1; ar_id = 4'd6; ar_len = 8'd7; r_ready = 0;
      @(negedge clk);
      ar_valid = 0;
      beats = 0; cyc = 0; rr = 0; prev_stall = 0; prev = '0;
      while (beats < 8 && cyc < 50) begin
         vec++;
         if (r_valid !== 1'b1) begin
            errs++; $display("FAIL bp_rvalid got %b want 1 at beat %0d", r_valid, beats);
         end
         if (prev_stall) begin
            vec++;
            if ({r_id, r_data, r_last} !== prev) begin
               errs++; $display("FAIL bp_stable got %h want %h", {r_id, r_data, r_last}, prev);
            end
         end
         rr = ~rr;
         r_ready = rr;
         if (r_valid && rr) begin
            vec++;
            if ({r_last, r_id} !== {(beats == 7), 4'd6}) begin
               errs++; $display("FAIL bp_last beat %0d got last=%b id=%0d want %b/6", beats, r_last, r_id, (beats == 7));
            end
            beats++;
         end
         prev_stall = r_valid && !rr;
         prev = {r_id, r_data, r_last};
         @(negedge clk);
         cyc++;
      end
      r_ready = 0;
      vec++;
      if (beats != 8) begin
         errs++; $display("FAIL bp_timeout got %0d beats want 8", beats);
      end
      exp_rd++;
      vec++;
      if ({r_valid, ar_ready, rd_cnt} !== {1'b0, 1'b1, sat(exp_rd)}) begin
         errs++; $display("FAIL bp_rdone got r_valid=%b ar_ready=%b rd_cnt=%0d want 0/1/%0d", r_valid, ar_ready, rd_cnt, sat(exp_rd));
      end
      // Write response held off for 10 cycles
      aw_valid = 1; aw_id = 4'd9;
      @(negedge clk);
      aw_valid = 0; w_valid = 1; w_last = 1; b_ready = 0;
      @(negedge clk);
      w_valid = 0; w_last = 0;
      for (int i = 0; i < 10; i++) begin
         vec++;
         if ({b_valid, b_id, aw_ready} !== {1'b1, 4'd9, 1'b0}) begin
            errs++; $display("FAIL bp_bhold cyc %0d got v=%b id=%0d aw_ready=%b want 1/9/0", i, b_valid, b_id, aw_ready);
         end
         @(negedge clk);
      end
      b_ready = 1;
      @(negedge clk);
      b_ready = 0;
      exp_wr++;
      vec++;
      if ({b_valid, aw_ready, wr_cnt} !== {1'b0, 1'b1, sat(exp_wr)}) begin
         errs++; $display("FAIL bp_wdone got b_valid=%b aw_ready=%b wr_cnt=%0d want 0/1/%0d", b_valid, aw_ready, wr_cnt, sat(exp_wr));
      end
   endtask

   task automatic test_concurrency();
      aw_valid = 1; aw_id = 4'd1; ar_valid = 1; ar_id = 4'd2; ar_len = 8'd0;
      @(negedge clk);
      aw_valid = 0; ar_valid = 0;
      vec++;
      if ({w_ready, r_valid, r_id, r_last} !== {1'b1, 1'b1, 4'd2, 1'b1}) begin
         errs++; $display("FAIL cc_accept got w_ready=%b r_valid=%b r_id=%0d r_last=%b want 1/1/2/1", w_ready, r_valid, r_id, r_last);
      end
      w_valid = 1; w_last = 1; r_ready = 1; b_ready = 1;
      @(negedge clk);
      w_valid = 0; w_last = 0; r_ready = 0;
      exp_rd++;
      vec++;
      if ({b_valid, b_id, r_valid, rd_cnt} !== {1'b1, 4'd1, 1'b0, sat(exp_rd)}) begin
         errs++; $display("FAIL cc_resp got b_valid=%b b_id=%0d r_valid=%b rd_cnt=%0d want 1/1/0/%0d", b_valid, b_id, r_valid, rd_cnt, sat(exp_rd));
      end
      @(negedge clk);
      b_ready = 0;
      exp_wr++;
      vec++;
      if ({b_valid, wr_cnt} !== {1'b0, sat(exp_wr)}) begin
         errs++; $display("FAIL cc_wdone got b_valid=%b wr_cnt=%0d want 0/%0d", b_valid, wr_cnt, sat(exp_wr));
      end
   endtask

   task automatic test_early_w();
      w_valid = 1; w_last = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++;
         if (w_ready !== 1'b0) begin
            errs++; $display("FAIL ew_stall cyc %0d got w_ready=%b want 0", i, w_ready);
         end
      end
      aw_valid = 1; aw_id = 4'd7;
      vec++;
      if (w_ready !== 1'b0) begin
         errs++; $display("FAIL ew_aw_cycle got w_ready=%b want 0", w_ready);
      end
      @(negedge clk);
      aw_valid = 0; b_ready = 1;
      vec++;
      if (w_ready !== 1'b1) begin
         errs++; $display("FAIL ew_open got w_ready=%b want 1", w_ready);
      end
      @(negedge clk);
      w_valid = 0; w_last = 0;
      vec++;
      if ({b_valid, b_id} !== {1'b1, 4'd7}) begin
         errs++; $display("FAIL ew_resp got b_valid=%b b_id=%0d want 1/7", b_valid, b_id);
      end
      @(negedge clk);
      b_ready = 0;
      exp_wr++;
      vec++;
      if (wr_cnt !== sat(exp_wr)) begin
         errs++; $display("FAIL ew_cnt got %0d want %0d", wr_cnt, sat(exp_wr));
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 2; i++) begin
         aw_valid = 1; aw_id = 4'(i);
         @(negedge clk);
         aw_valid = 0; w_valid = 1; w_last = 1; b_ready = 1;
         @(negedge clk);
         w_valid = 0; w_last = 0;
         @(negedge clk);
         b_ready = 0;
         exp_wr++;
         vec++;
         if (wr_cnt !== sat(exp_wr)) begin
            errs++; $display("FAIL sat_wr after %0d writes got %0d want %0d", exp_wr, wr_cnt, sat(exp_wr));
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      ar_valid = 1; ar_id = 4'd4; ar_len = 8'd5; r_ready = 0;
      @(negedge clk);
      ar_valid = 0;
      vec++;
      if (r_valid !== 1'b1) begin
         errs++; $display("FAIL rm_rdata got r_valid=%b want 1", r_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      vec++;
      if ({r_valid, r_last, ar_ready, rd_cnt, wr_cnt} !== {1'b0, 1'b0, 1'b1, {CW{1'b0}}, {CW{1'b0}}}) begin
         errs++; $display("FAIL rm_async got r_valid=%b r_last=%b ar_ready=%b rd=%0d wr=%0d want 0/0/1/0/0", r_valid, r_last, ar_ready, rd_cnt, wr_cnt);
      end
      exp_wr = 0; exp_rd = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vec++;
      if ({ar_ready, r_valid} !== 2'b10) begin
         errs++; $display("FAIL rm_release got ar_ready=%b r_valid=%b want 1/0", ar_ready, r_valid);
      end
   endtask

   // Random traffic against a transaction-level model: one write and one read
   // transaction may be in flight; each is tracked as an outstanding record.
   task automatic test_random();
      logic          m_wbusy, m_wlast, m_rbusy;
      logic [IW-1:0] m_wid, m_rid;
      int            m_rlen, m_rbeat;
      logic          e_bv, e_rv;
      m_wbusy = 0; m_wlast = 0; m_rbusy = 0; m_wid = 0; m_rid = 0; m_rlen = 0; m_rbeat = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         e_bv = m_wbusy && m_wlast;
         e_rv = m_rbusy;
         vec++;
         if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, wr_cnt, rd_cnt} !==
             {!m_wbusy, m_wbusy && !m_wlast, e_bv, !m_rbusy, e_rv, e_rv && (m_rbeat == m_rlen),
              sat(exp_wr), sat(exp_rd)}) begin
            errs++; $display("FAIL rnd_ctrl cyc %0d got awr=%b wr=%b bv=%b arr=%b rv=%b rl=%b wc=%0d rc=%0d", cyc,
                             aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, wr_cnt, rd_cnt);
         end
         if (e_bv) begin
            vec++;
            if ({b_id, b_resp} !== {m_wid, ERR}) begin
               errs++; $display("FAIL rnd_b cyc %0d got id=%0d resp=%b want %0d/11", cyc, b_id, b_resp, m_wid);
            end
         end
         if (e_rv) begin
            vec++;
            if ({r_id, r_data, r_resp} !== {m_rid, RD, ERR}) begin
               errs++; $display("FAIL rnd_r cyc %0d got id=%0d data=%h resp=%b want %0d", cyc, r_id, r_data, r_resp, m_rid);
            end
         end
         // Initiator side: hold a pending request until accepted.
         if (!(aw_valid && !aw_ready)) begin aw_valid = 1'($urandom); aw_id = IW'($urandom); end
         if (!(w_valid && !w_ready))   begin w_valid = 1'($urandom); w_last = ($urandom_range(0, 2) == 0); end
         if (!(ar_valid && !ar_ready)) begin ar_valid = 1'($urandom); ar_id = IW'($urandom); ar_len = 8'($urandom_range(0, 6)); end
         b_ready = 1'($urandom);
         r_ready = 1'($urandom);
         // Transactions completed at the coming edge.
         if (aw_valid && !m_wbusy) begin
            m_wbusy = 1; m_wlast = 0; m_wid = aw_id;
         end else if (m_wbusy && !m_wlast && w_valid && w_last) begin
            m_wlast = 1;
         end else if (e_bv && b_ready) begin
            m_wbusy = 0; m_wlast = 0; exp_wr++;
         end
         if (ar_valid && !m_rbusy) begin
            m_rbusy = 1; m_rid = ar_id; m_rlen = int'(ar_len); m_rbeat = 0;
         end else if (m_rbusy && r_ready) begin
            if (m_rbeat == m_rlen) begin m_rbusy = 0; exp_rd++; end
            else m_rbeat++;
         end
         @(negedge clk);
      end
      aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 0; r_ready = 0;
   endtask

   initial begin
      vec = 0; errs = 0; exp_wr = 0; exp_rd = 0;
      @(negedge clk);
      test_reset();
      test_single_write();
      test_read_burst();
      test_backpressure();
      test_concurrency();
      test_early_w();
      test_saturation();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
